// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder sequencer/arbiter: state encoding,
// nibble width and a width helper for index and counter registers.
package adder_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int NIBBLE_W = 4;

  // Bits needed to index n items, never less than one bit.
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/adder_nibble.sv
// The shared arithmetic resource: one 4-bit slice adding two nibbles and a
// carry-in, producing a 5-bit {carry, sum}. Purely combinational.
module adder_nibble
  import adder_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, ci_i};

endmodule

// File: rtl/adder_seq_arb.sv
// Round-robin arbiter and nibble-serial sequencer in front of a single
// adder_nibble slice. The granted requester's operands are latched, then
// added LSB nibble first, one nibble per cycle, with the carry held in a
// register between nibbles. A one-cycle done pulse presents the result.
module adder_seq_arb
  import adder_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NIBBLES = 4,
  localparam int W      = NIBBLE_W * NIBBLES,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ-1:0]   ci_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      sum_out,
  output logic              co_out
);

  localparam int CW = id_width(NIBBLES);
  localparam logic [CW-1:0]  LAST_NIB = CW'(NIBBLES - 1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  // FSM state
  state_t state_q, state_d;

  // Arbitration and operation context
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  // Datapath: operands shift right one nibble per step, the sum shifts in
  // from the top so the full result is aligned after the last nibble.
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Registered outputs
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            co_q, co_d;

  // Arbitration result and slice result
  logic [IDW:0]      pick_s;
  logic              pick_found_s;
  logic [IDW-1:0]    pick_idx_s;
  logic [NIBBLE_W:0] slice_sum_s;

  // First requester after 'last', wrapping; returns {found, index}.
  // Scanning from the farthest candidate lets the nearest one win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0] res;
    int           cand;
    res = {(IDW+1){1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(last) + i) % NREQ;
      if (r[cand]) begin
        res = {1'b1, cand[IDW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s       = rr_pick(req, ptr_q);
  assign pick_found_s = pick_s[IDW];
  assign pick_idx_s   = pick_s[IDW-1:0];

  adder_nibble u_slice (
    .a_i   (a_q[NIBBLE_W-1:0]),
    .b_i   (b_q[NIBBLE_W-1:0]),
    .ci_i  (carry_q),
    .sum_o (slice_sum_s)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant on any request, NIBBLES calc cycles, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST_NIB) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values for each state.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    co_d      = co_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          gnt_d     = NREQ'(1) << pick_idx_s;
          gnt_idx_d = pick_idx_s;
          a_d       = a_in[pick_idx_s*W +: W];
          b_d       = b_in[pick_idx_s*W +: W];
          carry_d   = ci_in[pick_idx_s];
          cnt_d     = {CW{1'b0}};
          acc_d     = {W{1'b0}};
          busy_d    = 1'b1;
        end else begin
          gnt_d  = {NREQ{1'b0}};
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        acc_d   = {slice_sum_s[NIBBLE_W-1:0], acc_q[W-1:NIBBLE_W]};
        carry_d = slice_sum_s[NIBBLE_W];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_NIB) begin
          sum_d     = acc_d;
          co_d      = slice_sum_s[NIBBLE_W];
          done_d    = 1'b1;
          done_id_d = gnt_idx_q;
        end else begin
          done_d = 1'b0;
        end
      end
      S_DONE: begin
        gnt_d  = {NREQ{1'b0}};
        busy_d = 1'b0;
        ptr_d  = gnt_idx_q;
      end
      default: begin
        gnt_d  = {NREQ{1'b0}};
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any partial operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q     <= {NREQ{1'b0}};
      gnt_idx_q <= {IDW{1'b0}};
      ptr_q     <= PTR_RST;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      acc_q     <= {W{1'b0}};
      carry_q   <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
      sum_q     <= {W{1'b0}};
      co_q      <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      co_q      <= co_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum_out = sum_q;
  assign co_out  = co_q;

endmodule

// File: tb/tb_adder_seq_arb.sv
// Directed bench for adder_seq_arb (NREQ=2, NIBBLES=4). Expected results are
// queued when stimulus is issued; a monitor pops and compares on each done.
module tb_adder_seq_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [1:0]  ci_in;
  logic [1:0]  gnt;
  logic        busy;
  logic        done;
  logic [0:0]  done_id;
  logic [15:0] sum_out;
  logic        co_out;

  typedef struct packed {
    logic [0:0]  id;
    logic [15:0] sum;
    logic        co;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  int   lat;

  adder_seq_arb #(.NREQ(2), .NIBBLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .ci_in   (ci_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum_out (sum_out),
    .co_out  (co_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [15:0] sum, input logic co);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    e.co  = co;
    exp_q.push_back(e);
  endtask

  // Counts falling edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done_id=%0d sum=%0h with nothing expected", done_id, sum_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_done_id", 32'(done_id), 32'(e.id));
        chk("sb_sum",     32'(sum_out), 32'(e.sum));
        chk("sb_co",      32'(co_out),  32'(e.co));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 2'b00;
    a_in  = 32'h0;
    b_in  = 32'h0;
    ci_in = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_gnt",     32'(gnt),     32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_done",    32'(done),    32'h0);
    chk("rst_done_id", 32'(done_id), 32'h0);
    chk("rst_sum",     32'(sum_out), 32'h0);
    chk("rst_co",      32'(co_out),  32'h0);
    reset = 1'b0;

    // 1: simple add on requester 0
    a_in[15:0] = 16'h1234;
    b_in[15:0] = 16'h1111;
    ci_in      = 2'b00;
    req        = 2'b01;
    push(1'b0, 16'h2345, 1'b0);
    @(negedge clk);
    chk("t1_gnt",  32'(gnt),  32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 2'b00;
    wait_done(lat);
    chk("t1_latency",   32'(lat), 32'd4);
    chk("t1_gnt_done",  32'(gnt), 32'h1);
    chk("t1_busy_done", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_gnt_drop",  32'(gnt),  32'h0);
    chk("t1_busy_drop", 32'(busy), 32'h0);

    // 2: full carry ripple on requester 1
    a_in[31:16] = 16'hFFFF;
    b_in[31:16] = 16'h0000;
    ci_in       = 2'b10;
    req         = 2'b10;
    push(1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    wait_done(lat);
    chk("t2_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk);

    // 3: both requesting after reset, round-robin alternation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a_in  = {16'h8000, 16'h0001};
    b_in  = {16'h8000, 16'h0001};
    ci_in = 2'b00;
    req   = 2'b11;
    push(1'b0, 16'h0002, 1'b0);
    push(1'b1, 16'h0000, 1'b1);
    push(1'b0, 16'h0002, 1'b0);
    push(1'b1, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("t3_gap_gnt", 32'(gnt), 32'h0);
      end
      @(negedge clk);
      chk("t3_rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      wait_done(lat);
      chk("t3_latency", 32'(lat), 32'd4);
      if (k == 3) begin
        req = 2'b00;
      end
    end
    @(negedge clk);

    // 4: operand change after grant is ignored
    a_in[15:0] = 16'h00FF;
    b_in[15:0] = 16'h0001;
    ci_in      = 2'b00;
    req        = 2'b01;
    push(1'b0, 16'h0100, 1'b0);
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h1);
    a_in[15:0] = 16'h0000;
    ci_in      = 2'b01;
    req        = 2'b00;
    wait_done(lat);
    chk("t4_latency", 32'(lat), 32'd4);
    @(negedge clk);

    // 5: request dropped in nibble 1; op completes, no second grant
    a_in[15:0] = 16'h0F0F;
    b_in[15:0] = 16'h0101;
    ci_in      = 2'b01;
    req        = 2'b01;
    push(1'b0, 16'h1011, 1'b0);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 2'b00;
    wait_done(lat);
    chk("t5_latency", 32'(lat), 32'd3);
    @(negedge clk);
    chk("t5_gnt_drop", 32'(gnt), 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_no_regrant", 32'(gnt),     32'h0);
    chk("t5_sum_hold",   32'(sum_out), 32'h1011);

    // 6: reset in nibble 2 aborts; after release requester 0 wins
    a_in  = {16'h8000, 16'h0001};
    b_in  = {16'h8000, 16'h0001};
    ci_in = 2'b00;
    req   = 2'b11;
    @(negedge clk);
    chk("t6_gnt_first", 32'(gnt), 32'h2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_gnt",     32'(gnt),     32'h0);
    chk("t6_rst_busy",    32'(busy),    32'h0);
    chk("t6_rst_done",    32'(done),    32'h0);
    chk("t6_rst_sum",     32'(sum_out), 32'h0);
    chk("t6_rst_co",      32'(co_out),  32'h0);
    chk("t6_rst_done_id", 32'(done_id), 32'h0);
    push(1'b0, 16'h0002, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_gnt_after_rst", 32'(gnt), 32'h1);
    wait_done(lat);
    chk("t6_latency", 32'(lat), 32'd4);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
